bcd_display_mux: RTL

BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

---
 rtl/bcd_display_pkg.sv | 13 +
 rtl/bcd_to_seg7.sv | 9 +
 rtl/bcd_display_mux.sv | 94 +++++++++
 3 files changed

// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg: shared widths and segment encodings for the multiplexed BCD display
package bcd_display_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_W = 4;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    {6{SEG_DASH}},
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: active-low seven-segment pattern for one BCD digit, dash for non-BCD codes
module bcd_to_seg7
  import bcd_display_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [SEG_W-1:0] seg_o
);
  assign seg_o = SEG_TABLE[bcd_i];
endmodule

// File: rtl/bcd_display_mux.sv
// bcd_display_mux: time-multiplexed 4-digit BCD display driver with frame-synchronous capture
module bcd_display_mux
  import bcd_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic                          CLK,
  input  logic                          CLR,
  input  logic [NUM_DIGITS*BCD_W-1:0]   D,
  input  logic [NUM_DIGITS-1:0]         DP,
  input  logic                          LZB,
  input  logic                          EN,
  output logic [NUM_DIGITS-1:0]         AN,
  output logic [SEG_W-1:0]              SEG,
  output logic                          DP_N,
  output logic                          FRAME
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0] idx_q, idx_d;
  logic [NUM_DIGITS*BCD_W-1:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
  logic lzb_q, lzb_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic dpn_q, dpn_d;
  logic frame_q, frame_d;
  logic tick, cap, run;
  logic [NUM_DIGITS-1:0] blank;
  logic [BCD_W-1:0] cur_dig;
  logic [SEG_W-1:0] dec_seg;

  assign cur_dig = dig_q[idx_q*BCD_W +: BCD_W];

  bcd_to_seg7 u_dec (
    .bcd_i (cur_dig),
    .seg_o (dec_seg)
  );

  // Leading-zero blanking: a digit is dark when it and every digit above it are zero; digit 0 always lit
  always_comb begin
    blank = '0;
    run = lzb_q;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      run = run && (dig_q[k*BCD_W +: BCD_W] == '0);
      blank[k] = run;
    end
  end

  // Scan timing, frame capture and next registered display outputs
  always_comb begin
    tick = EN && (presc_q == PW'(SCAN_DIV - 1));
    cap = tick && (idx_q == 2'(NUM_DIGITS - 1));
    presc_d = !EN ? presc_q : tick ? '0 : presc_q + PW'(1);
    idx_d = tick ? idx_q + 2'd1 : idx_q;
    dig_d = cap ? D : dig_q;
    dp_d = cap ? DP : dp_q;
    lzb_d = cap ? LZB : lzb_q;
    an_d = EN ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    seg_d = (!EN || blank[idx_q]) ? SEG_BLANK : dec_seg;
    dpn_d = !EN || blank[idx_q] || !dp_q[idx_q];
    frame_d = cap;
  end

  // State and output registers, cleared asynchronously while CLR is low
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      presc_q <= '0;
      idx_q <= '0;
      dig_q <= '0;
      dp_q <= '0;
      lzb_q <= 1'b0;
      an_q <= '1;
      seg_q <= SEG_BLANK;
      dpn_q <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q <= idx_d;
      dig_q <= dig_d;
      dp_q <= dp_d;
      lzb_q <= lzb_d;
      an_q <= an_d;
      seg_q <= seg_d;
      dpn_q <= dpn_d;
      frame_q <= frame_d;
    end
  end

  assign AN = an_q;
  assign SEG = seg_q;
  assign DP_N = dpn_q;
  assign FRAME = frame_q;
endmodule
